bcd_neg_sequencer: RTL and testbench

- Controller that walks every entry of a matrix register file and converts each signed-BCD entry to ten's-complement form.
- Each entry is read, driven through the external BCD negation datapath (`neg_input`), and written back in place.
- Sits between the matrix register file and the arithmetic unit. The top-level FSM runs it once before any add/subtract/multiply pass.
- Entry format: 9 bits. Bit 8 is the sign (1 = negative); bits [7:4] and [3:0] are BCD tens and units.

---
 rtl/bcd_neg_sequencer.sv | 128 ++++++++++++
 tb/tb_bcd_neg_sequencer.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_neg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bcd_neg_sequencer
// Description : Walks every matrix register-file entry, passes it through the
//               external BCD negation datapath and writes it back in place.
//               Optional macro NEG_ZERO_CANON_EN canonicalises 9'h100 to 9'h000.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_neg_sequencer #(
    parameter int N_ENTRIES = 9,
    parameter int ADDR_W    = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [8:0]        rd_data,
    output logic [8:0]        conv_in,
    input  logic [8:0]        conv_out,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [8:0]        wr_data,
    output logic [4:0]        neg_count
);

    localparam logic [ADDR_W-1:0] C_LAST_INDEX = ADDR_W'(N_ENTRIES - 1);
    localparam logic [4:0]        C_NEG_MAX    = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_CONV  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_index;
    logic [8:0]        r_result;
    logic [4:0]        r_neg_cnt;
    logic [4:0]        r_neg_count;
    logic              w_neg_zero;
    logic [8:0]        w_capture;
    logic              w_count_neg;

`ifdef NEG_ZERO_CANON_EN
    assign w_neg_zero = (rd_data == 9'h100);
`else
    assign w_neg_zero = 1'b0;
`endif

    assign w_capture   = w_neg_zero ? 9'h000 : conv_out;
    assign w_count_neg = rd_data[8] && !w_neg_zero;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Abort overrides every transition out of a non-idle state.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start && !abort) w_next = S_READ;
            S_READ:  w_next = S_CONV;
            S_CONV:  w_next = S_WRITE;
            S_WRITE: w_next = (r_index == C_LAST_INDEX) ? S_DONE : S_READ;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_index     <= '0;
            r_result    <= 9'h000;
            r_neg_cnt   <= 5'd0;
            r_neg_count <= 5'd0;
        end else if (!abort) begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_index   <= '0;
                        r_neg_cnt <= 5'd0;
                    end
                end
                S_CONV: begin
                    r_result <= w_capture;
                    if (w_count_neg && (r_neg_cnt != C_NEG_MAX)) begin
                        r_neg_cnt <= r_neg_cnt + 5'd1;
                    end
                end
                S_WRITE: begin
                    if (r_index != C_LAST_INDEX) begin
                        r_index <= r_index + 1'b1;
                    end
                end
                S_DONE:  r_neg_count <= r_neg_cnt;
                default: ;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    always_comb begin
        busy    = (r_state != S_IDLE);
        done    = (r_state == S_DONE) && !abort;
        rd_addr = (r_state != S_IDLE) ? r_index : '0;
        conv_in = (r_state == S_CONV) ? rd_data : 9'h000;
        wr_en   = (r_state == S_WRITE) && !abort;
        wr_addr = (r_state == S_WRITE) ? r_index : '0;
        wr_data = (r_state == S_WRITE) ? r_result : 9'h000;
    end

    assign neg_count = r_neg_count;

endmodule
`default_nettype wire

// File: tb/tb_bcd_neg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bcd_neg_sequencer
// Description : Self-checking bench with register-file and negation-datapath
//               models and an arithmetic reference for expected write-backs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bcd_neg_sequencer;

    localparam int N = 9;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, wr_en;
    logic [3:0] rd_addr, wr_addr;
    logic [8:0] rd_data = 9'h000;
    logic [8:0] conv_in, conv_out, wr_data;
    logic [4:0] neg_count;

    logic [8:0] mem [0:15];
    logic [3:0] log_addr [$];
    logic [8:0] log_data [$];
    int         done_cnt = 0;
    int         checks = 0;
    int         failures = 0;
    int         exp_nc = 0;

    bcd_neg_sequencer #(.N_ENTRIES(N), .ADDR_W(4)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
        .conv_in(conv_in), .conv_out(conv_out), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .neg_count(neg_count)
    );

    always #5 clk = ~clk;

    // Ten's complement of a signed two-digit BCD value; sign bit kept.
    function automatic logic [8:0] neg_model(input logic [8:0] v);
        int         mag;
        logic [3:0] t, u;
        if (!v[8]) return v;
        mag = (100 - (int'(v[7:4]) * 10 + int'(v[3:0]))) % 100;
        t = 4'(mag / 10);
        u = 4'(mag % 10);
        return {1'b1, t, u};
    endfunction

    function automatic bit canon_on();
`ifdef NEG_ZERO_CANON_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [8:0] exp_write(input logic [8:0] v);
        if (canon_on() && v == 9'h100) return 9'h000;
        return neg_model(v);
    endfunction

    function automatic int exp_negs(input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            if (mem[i][8] && !(canon_on() && mem[i] == 9'h100)) c++;
        return c;
    endfunction

    assign conv_out = neg_model(conv_in);

    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) begin
        if (wr_en) begin
            mem[wr_addr] = wr_data;
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (done) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
        done_cnt = 0;
    endtask

    // Pulses start and waits for done; cycles counts edges from the sampling edge.
    task automatic run_pass(input bit mid_start, output int cycles);
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        cycles = 1;
        while (!done && cycles < 200) begin
            start = (mid_start && cycles == 8) ? 1'b1 : 1'b0;
            tick();
            cycles++;
        end
        start = 1'b0;
        if (!done) begin
            failures++;
            $display("FAIL pass_timeout: no done after %0d cycles", cycles);
        end
        tick();
    endtask

    task automatic check_pass(input string name, input logic [8:0] orig [0:N-1], input int cycles);
        checks++;
        if (cycles !== 3 * N + 1) begin
            failures++;
            $display("FAIL %s_latency: got %0d expected %0d", name, cycles, 3 * N + 1);
        end
        checks++;
        if (log_addr.size() !== N || done_cnt !== 1) begin
            failures++;
            $display("FAIL %s_counts: writes=%0d dones=%0d expected %0d/1", name, log_addr.size(), done_cnt, N);
        end else begin
            for (int i = 0; i < N; i++) begin
                checks++;
                if (log_addr[i] !== 4'(i) || log_data[i] !== exp_write(orig[i])) begin
                    failures++;
                    $display("FAIL %s_write%0d: addr=%0d data=%h expected addr=%0d data=%h",
                             name, i, log_addr[i], log_data[i], i, exp_write(orig[i]));
                end
            end
        end
        checks++;
        if (neg_count !== 5'(exp_nc)) begin
            failures++;
            $display("FAIL %s_neg_count: got %0d expected %0d", name, neg_count, exp_nc);
        end
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) tick();
        nrst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || wr_en !== 1'b0 || neg_count !== 5'd0 ||
                rd_addr !== 4'd0 || wr_data !== 9'h000 || conv_in !== 9'h000) begin
                failures++;
                $display("FAIL reset_idle%0d: busy=%b done=%b wr_en=%b neg_count=%0d expected all 0",
                         i, busy, done, wr_en, neg_count);
            end
        end
    endtask

    task automatic test_mixed();
        logic [8:0] orig [0:N-1];
        logic [8:0] want [0:N-1];
        int cycles;
        orig = '{9'h125, 9'h042, 9'h101, 9'h000, 9'h199, 9'h050, 9'h110, 9'h007, 9'h099};
        want = '{9'h175, 9'h042, 9'h199, 9'h000, 9'h101, 9'h050, 9'h190, 9'h007, 9'h099};
        for (int i = 0; i < N; i++) mem[i] = orig[i];
        run_pass(1'b0, cycles);
        exp_nc = 4;
        check_pass("mixed", orig, cycles);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (mem[i] !== want[i]) begin
                failures++;
                $display("FAIL mixed_mem%0d: got %h expected %h", i, mem[i], want[i]);
            end
        end
    endtask

    task automatic test_neg_zero();
        logic [8:0] orig [0:N-1];
        int cycles;
        for (int i = 0; i < N; i++) begin
            mem[i] = (i == 0) ? 9'h100 : 9'h033;
            orig[i] = mem[i];
        end
        run_pass(1'b0, cycles);
        exp_nc = canon_on() ? 0 : 1;
        check_pass("neg_zero", orig, cycles);
    endtask

    task automatic test_random();
        logic [8:0] orig [0:N-1];
        int cycles;
        for (int p = 0; p < 4; p++) begin
            for (int i = 0; i < N; i++) begin
                mem[i] = {1'($urandom_range(0, 1)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                if ($urandom_range(0, 7) == 0) mem[i] = 9'h100;
                orig[i] = mem[i];
            end
            exp_nc = exp_negs(N);
            run_pass(1'b0, cycles);
            check_pass("random", orig, cycles);
        end
    endtask

    task automatic test_abort();
        logic [8:0] orig [0:N-1];
        int cycles;
        bit hit = 0;
        for (int i = 0; i < N; i++) begin
            mem[i] = (i % 2 == 1) ? 9'h160 : 9'h021;
            orig[i] = mem[i];
        end
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (wr_en && wr_addr == 4'd4) begin
                hit = 1;
                abort = 1'b1;
                #1;
                checks++;
                if (wr_en !== 1'b0) begin
                    failures++;
                    $display("FAIL abort_wr_en: got %b expected 0", wr_en);
                end
                tick();
                abort = 1'b0;
            end else begin
                tick();
            end
        end
        repeat (3) tick();
        checks++;
        if (!hit || busy !== 1'b0 || log_addr.size() !== 4 || done_cnt !== 0 || neg_count !== 5'(exp_nc)) begin
            failures++;
            $display("FAIL abort_state: hit=%0d busy=%b writes=%0d dones=%0d neg_count=%0d expected 1/0/4/0/%0d",
                     hit, busy, log_addr.size(), done_cnt, neg_count, exp_nc);
        end
        for (int i = 0; i < N; i++) orig[i] = mem[i];
        exp_nc = exp_negs(N);
        run_pass(1'b0, cycles);
        check_pass("after_abort", orig, cycles);
    endtask

    task automatic test_back_to_back();
        logic [8:0] orig [0:N-1];
        int cycles;
        for (int i = 0; i < N; i++) begin
            mem[i] = {1'(i % 3 == 0), 4'(i), 4'(9 - i)};
            orig[i] = mem[i];
        end
        exp_nc = exp_negs(N);
        run_pass(1'b1, cycles);
        check_pass("start_busy", orig, cycles);
        tick();
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL start_busy_idle: busy=%b expected 0", busy);
        end
    endtask

    task automatic test_async_reset();
        bit hit = 0;
        for (int i = 0; i < N; i++) mem[i] = 9'h145;
        clear_log();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            if (wr_en && wr_addr == 4'd5) begin
                hit = 1;
                nrst = 1'b0;
                #1;
                checks++;
                if (wr_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || neg_count !== 5'd0) begin
                    failures++;
                    $display("FAIL async_reset_outputs: wr_en=%b busy=%b done=%b neg_count=%0d expected 0",
                             wr_en, busy, done, neg_count);
                end
            end else begin
                tick();
            end
        end
        repeat (2) tick();
        nrst = 1'b1;
        repeat (10) tick();
        checks++;
        if (!hit || log_addr.size() !== 5 || busy !== 1'b0 || done_cnt !== 0) begin
            failures++;
            $display("FAIL async_reset_writes: hit=%0d writes=%0d busy=%b dones=%0d expected 1/5/0/0",
                     hit, log_addr.size(), busy, done_cnt);
        end
        exp_nc = 0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 9'h000;
        test_reset();
        test_mixed();
        test_neg_zero();
        test_random();
        test_abort();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
